fifo_rd_stream: RTL and testbench

Read-side adapter for the synchronous FIFO: pops words through the FIFO's `rd_en`/`empty` port and presents them as a valid/ready stream on the consumer side. It hides the FIFO read latency (combinational or registered `rd_data`) behind a 2-entry output buffer, so one word per cycle is sustained while `m_ready` stays high. It sits between a `sync_fifo` instance and any downstream consumer.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_skid_buf.sv | 62 ++++++
 rtl/fifo_rd_stream.sv | 104 ++++++++++
 tb/tb_fifo_rd_stream.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side stream adapter.
package fifo_pkg;
  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;
  localparam int CNT_WIDTH   = 16;
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer with 1-bit wrapping pointers and an occupancy count.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem_r [0:1];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            occ_r;
  logic [1:0]            occ_nxt_s;

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_nxt_s = occ_r;
    if (push && !pop) begin
      occ_nxt_s = occ_r + 2'd1;
    end else if (!push && pop) begin
      occ_nxt_s = occ_r - 2'd1;
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // Storage, pointers and count; flush empties the buffer without touching data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_nxt_s;
    end
  end

  assign occ       = occ_r;
  assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter hiding 0- or 1-cycle read latency.
// Optional transfer counter enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = RD_LAT_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic                  underflow_err,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic       pop_s;
  logic       push_s;
  logic       issue_s;
  logic [1:0] occ_s;
  logic [2:0] pending_s;
  logic       inflight_r;
  logic       underflow_r;

  assign m_valid = (occ_s != 2'd0);
  assign pop_s   = m_valid & m_ready;

  // Issue only while buffered plus in-flight words, net of this pop, leave a free slot.
  always_comb begin
    pending_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s   = 1'b0;
    if (rst || flush || fifo_empty) begin
      issue_s = 1'b0;
    end else begin
      issue_s = (pending_s < 3'd2);
    end
  end

  assign fifo_rd_en = issue_s;

  // Registered read data arrives one cycle after the issue; combinational data never waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 1'b0;
    end else if (RD_LATENCY == RD_LAT_COMB) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
    end
  end

  assign push_s = (RD_LATENCY == RD_LAT_COMB) ? issue_s : (inflight_r & ~flush);

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push_s),
    .push_data(fifo_rd_data),
    .pop      (pop_s),
    .occ      (occ_s),
    .head_data(m_data)
  );

  // Sticky flag for a pop issued against an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_r <= 1'b0;
    end else if (issue_s && fifo_empty) begin
      underflow_r <= 1'b1;
    end else begin
      underflow_r <= underflow_r;
    end
  end

  assign underflow_err = underflow_r;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] xfer_cnt_r;

  // Completed transfers, wrapping; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_r <= '0;
    end else if (pop_s) begin
      xfer_cnt_r <= xfer_cnt_r + CNT_WIDTH'(1);
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  assign xfer_cnt = xfer_cnt_r;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: registered-read (A) and combinational-read (B) instances
// fed by FIFO models sharing one word store, checked by tables and an in-order scoreboard.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        m_ready = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_clr = 1'b1;
  logic [7:0]  mem [0:255];
  int          tail = 0;
  int          head_a = 0;
  int          head_b = 0;
  logic [7:0]  rd_data_a = 8'h00;
  logic [7:0]  rd_data_b;
  logic        empty_a, empty_b, rd_en_a, rd_en_b, valid_a, valid_b, uf_a, uf_b;
  logic [7:0]  data_a, data_b;
  logic [15:0] cnt_a, cnt_b;
  int          n_tests = 0;
  int          n_fail = 0;

  int          exp_a = 0, exp_b = 0, pops_a = 0, pops_b = 0;
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0]  held_a = 8'h00, held_b = 8'h00;

  assign empty_a   = (head_a == tail);
  assign empty_b   = (head_b == tail);
  assign rd_data_b = mem[head_b[7:0]];

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_rd_en(rd_en_a),
    .fifo_rd_data(rd_data_a), .m_valid(valid_a), .m_ready(m_ready), .m_data(data_a),
    .flush(flush), .underflow_err(uf_a), .xfer_cnt(cnt_a));

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_rd_en(rd_en_b),
    .fifo_rd_data(rd_data_b), .m_valid(valid_b), .m_ready(m_ready), .m_data(data_b),
    .flush(flush), .underflow_err(uf_b), .xfer_cnt(cnt_b));

  // FIFO models: A has a registered read port, B a combinational one.
  always @(posedge clk) begin
    if (fifo_clr) begin
      head_a    <= 0;
      head_b    <= 0;
      rd_data_a <= 8'h00;
    end else begin
      if (rd_en_a && !empty_a) begin
        rd_data_a <= mem[head_a[7:0]];
        head_a    <= head_a + 1;
      end
      if (rd_en_b && !empty_b) begin
        head_b <= head_b + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: accepted words must be the FIFO words in order; flush resumes at the FIFO head.
  task automatic mon_one(input string nm, input logic v, input logic [7:0] d, input logic re,
                         input logic em, input logic uf, input logic [15:0] cnt, input int head,
                         inout int exp, inout int pops, inout logic hold, inout logic [7:0] held);
    logic [15:0] cexp;
    chk({nm, " underflow_err"}, {31'd0, uf}, 32'd0);
    chk({nm, " rd_en_while_empty"}, {31'd0, re & em}, 32'd0);
    if (hold) begin
      chk({nm, " hold_valid"}, {31'd0, v}, 32'd1);
      chk({nm, " hold_data"}, {24'd0, d}, {24'd0, held});
    end
`ifdef FIFO_RD_STREAM_CNT_EN
    cexp = pops[15:0];
`else
    cexp = 16'h0000;
`endif
    chk({nm, " xfer_cnt"}, {16'd0, cnt}, {16'd0, cexp});
    if (v && m_ready) begin
      chk({nm, " data_order"}, {24'd0, d}, {24'd0, mem[exp[7:0]]});
      exp++;
      pops++;
    end
    if (flush) exp = head;
    hold = v & ~m_ready & ~flush;
    held = d;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_a = head_a; exp_b = head_b; pops_a = 0; pops_b = 0;
        hold_a = 1'b0; hold_b = 1'b0;
      end else begin
        mon_one("A", valid_a, data_a, rd_en_a, empty_a, uf_a, cnt_a, head_a,
                exp_a, pops_a, hold_a, held_a);
        mon_one("B", valid_b, data_b, rd_en_b, empty_b, uf_b, cnt_b, head_b,
                exp_b, pops_b, hold_b, held_b);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset both DUTs and reload the FIFO with 0x11..0x18; returns just after rst drops.
  task automatic restart();
    rst = 1'b1; m_ready = 1'b0; flush = 1'b0; fifo_clr = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 + i);
    tail = 8;
    @(posedge clk); #1; fifo_clr = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  typedef struct packed {
    logic       restart;
    logic       rdy;
    logic       a_v;
    logic [7:0] a_d;
    logic       a_re;
    logic       b_v;
    logic [7:0] b_d;
    logic       b_re;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [0:NV-1];

  function automatic vec_t mk(input logic rs, input logic rdy, input logic av, input logic [7:0] ad,
                              input logic are, input logic bv, input logic [7:0] bd, input logic bre);
    vec_t v;
    v.restart = rs; v.rdy = rdy; v.a_v = av; v.a_d = ad; v.a_re = are;
    v.b_v = bv; v.b_d = bd; v.b_re = bre;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Stream, m_ready high throughout.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h12, 1'b1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 8'h13, 1'b1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 8'h14, 1'b1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 8'h14, 1'b1, 1'b1, 8'h15, 1'b1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 8'h15, 1'b1, 1'b1, 8'h16, 1'b1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 8'h16, 1'b1, 1'b1, 8'h17, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 8'h17, 1'b0, 1'b1, 8'h18, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 8'h18, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    // Backpressure: m_ready low for three cycles after 0x12 leaves A.
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h12, 1'b1);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 8'h13, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 8'h14, 1'b1);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 8'h14, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 8'h14, 1'b0);
    tbl[18] = mk(1'b0, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 8'h14, 1'b1);
    tbl[19] = mk(1'b0, 1'b1, 1'b1, 8'h14, 1'b1, 1'b1, 8'h15, 1'b1);
    tbl[20] = mk(1'b0, 1'b1, 1'b1, 8'h15, 1'b1, 1'b1, 8'h16, 1'b1);
    tbl[21] = mk(1'b0, 1'b1, 1'b1, 8'h16, 1'b1, 1'b1, 8'h17, 1'b0);
    tbl[22] = mk(1'b0, 1'b1, 1'b1, 8'h17, 1'b0, 1'b1, 8'h18, 1'b0);
    tbl[23] = mk(1'b0, 1'b1, 1'b1, 8'h18, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[24] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset state.
    @(posedge clk); #1; fifo_clr = 1'b0;
    @(negedge clk);
    chk("reset m_valid A", {31'd0, valid_a}, 32'd0);
    chk("reset m_valid B", {31'd0, valid_b}, 32'd0);
    chk("reset m_data A", {24'd0, data_a}, 32'd0);
    chk("reset m_data B", {24'd0, data_b}, 32'd0);
    chk("reset rd_en A", {31'd0, rd_en_a}, 32'd0);
    chk("reset xfer_cnt A", {16'd0, cnt_a}, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) begin
      if (tbl[k].restart) restart();
      m_ready = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d m_valid A", k), {31'd0, valid_a}, {31'd0, tbl[k].a_v});
      if (tbl[k].a_v) chk($sformatf("vec%0d m_data A", k), {24'd0, data_a}, {24'd0, tbl[k].a_d});
      chk($sformatf("vec%0d rd_en A", k), {31'd0, rd_en_a}, {31'd0, tbl[k].a_re});
      chk($sformatf("vec%0d m_valid B", k), {31'd0, valid_b}, {31'd0, tbl[k].b_v});
      if (tbl[k].b_v) chk($sformatf("vec%0d m_data B", k), {24'd0, data_b}, {24'd0, tbl[k].b_d});
      chk($sformatf("vec%0d rd_en B", k), {31'd0, rd_en_b}, {31'd0, tbl[k].b_re});
      @(posedge clk); #1;
    end
`ifndef FIFO_RD_STREAM_CNT_EN
    chk("xfer_cnt disabled A", {16'd0, cnt_a}, 32'd0);
    chk("xfer_cnt disabled B", {16'd0, cnt_b}, 32'd0);
`endif

    // Flush while A holds 0x13 with 0x14 in flight.
    restart();
    m_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    m_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush rd_en A", {31'd0, rd_en_a}, 32'd0);
    chk("flush rd_en B", {31'd0, rd_en_b}, 32'd0);
    @(posedge clk); #1; flush = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    chk("post-flush m_valid A", {31'd0, valid_a}, 32'd0);
    chk("post-flush m_valid B", {31'd0, valid_b}, 32'd0);
    @(negedge clk);
    chk("post-flush m_valid B+1", {31'd0, valid_b}, 32'd1);
    chk("post-flush m_data B", {24'd0, data_b}, 32'h15);
    @(negedge clk);
    chk("post-flush m_valid A+2", {31'd0, valid_a}, 32'd1);
    chk("post-flush m_data A", {24'd0, data_a}, 32'h15);
    chk("post-flush underflow A", {31'd0, uf_a}, 32'd0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;

    // Asynchronous reset raised between clock edges mid-stream.
    restart();
    m_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    #2;
    chk("pre-rst m_valid A", {31'd0, valid_a}, 32'd1);
    chk("pre-rst rd_en A", {31'd0, rd_en_a}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst m_valid A", {31'd0, valid_a}, 32'd0);
    chk("async rst m_valid B", {31'd0, valid_b}, 32'd0);
    chk("async rst rd_en A", {31'd0, rd_en_a}, 32'd0);
    chk("async rst rd_en B", {31'd0, rd_en_b}, 32'd0);
    chk("async rst m_data A", {24'd0, data_a}, 32'd0);
    chk("async rst xfer_cnt A", {16'd0, cnt_a}, 32'd0);
    chk("async rst xfer_cnt B", {16'd0, cnt_b}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end

`ifdef FIFO_RD_STREAM_CNT_EN
    // Counter wrap: 0xFFFE transfers, then three more.
    restart();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    tail = 70000;
    m_ready = 1'b1;
    for (int c = 0; c < 70000 && pops_a != 65534; c++) begin @(posedge clk); #1; end
    m_ready = 1'b0;
    @(negedge clk);
    chk("cnt reached 0xFFFE A", {16'd0, cnt_a}, 32'h0000FFFE);
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int c = 0; c < 20 && pops_a != 65537; c++) begin @(posedge clk); #1; end
    m_ready = 1'b0;
    @(negedge clk);
    chk("cnt wrapped A", {16'd0, cnt_a}, 32'h00000001);
    @(posedge clk); #1;
`endif

    // Randomized traffic with backpressure, flushes and FIFO refills.
    restart();
    for (int c = 0; c < 3000; c++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1 && (tail - head_a) < 200 && (tail - head_b) < 200) begin
        mem[tail[7:0]] = 8'($urandom_range(0, 255));
        tail++;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 50 && !(empty_a && empty_b && !valid_a && !valid_b); c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain all words A", exp_a, tail);
    chk("drain all words B", exp_b, tail);
    chk("drain idle A", {31'd0, valid_a}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
